roi_bin_downscale: RTL

- Upstream pixel-conditioning stage that feeds cnn_top.
- Takes the CMOS 8-bit grayscale stream, crops a fixed square region of interest (ROI), averages SCALE×SCALE pixel blocks and thresholds each block average.
- Emits an OUT_W×OUT_H binary image as vsync / bin_data_vld / bin_data, the exact triple cnn_top consumes.
- Replaces the simulation-only pattern generator in the real camera path.

---
 rtl/roi_bin_downscale.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/roi_bin_downscale.sv
// Crops a square ROI from a raster grayscale stream, box-averages SCALExSCALE blocks
// and thresholds each block into one binary pixel for the downstream CNN.
`timescale 1ns/1ps
module roi_bin_downscale #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ROI_X  = 208,
    parameter int ROI_Y  = 128,
    parameter int OUT_W  = 28,
    parameter int OUT_H  = 28,
    parameter int SCALE  = 8,
    parameter int THRESH = 100
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       cmos_vsync,
    input  logic       gray_data_vld,
    input  logic [7:0] gray_data,
    output logic       vsync,
    output logic       bin_data_vld,
    output logic       bin_data,
    output logic       frame_done
);

    localparam int LOG_S = $clog2(SCALE);
    localparam int ACC_W = 8 + 2 * LOG_S;
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int SW    = LOG_S;
    localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OCW   = $clog2(OUT_W * OUT_H + 1);

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]    COL_LO   = CW'(ROI_X);
    localparam logic [CW-1:0]    COL_HI   = CW'(ROI_X + OUT_W * SCALE);
    localparam logic [RW-1:0]    ROW_LO   = RW'(ROI_Y);
    localparam logic [RW-1:0]    ROW_HI   = RW'(ROI_Y + OUT_H * SCALE);
    localparam logic [SW-1:0]    S_LAST   = SW'(SCALE - 1);
    localparam logic [BW-1:0]    B_LAST   = BW'(OUT_W - 1);
    localparam logic [OCW-1:0]   O_LAST   = OCW'(OUT_W * OUT_H - 1);
    // Comparing the block sum against THRESH*SCALE^2 avoids a divide for the average.
    localparam logic [ACC_W-1:0] THR_SUM  = ACC_W'(THRESH * SCALE * SCALE);

    logic             vs_d1_reg, vs_d2_reg;
    logic             armed_reg;
    logic [CW-1:0]    col_cnt_reg;
    logic [RW-1:0]    row_cnt_reg;
    logic [SW-1:0]    sub_x_reg, sub_y_reg;
    logic [BW-1:0]    bx_reg;
    logic [OCW-1:0]   out_cnt_reg;
    logic [ACC_W-1:0] acc [OUT_W];

    logic             vs_fall, vs_rise, pix_take, in_roi, roi_pix;
    logic             blk_first, blk_last;
    logic [ACC_W-1:0] pix_ext, sum_next;

    assign vs_fall   = vs_d2_reg & ~vs_d1_reg;
    assign vs_rise   = ~vs_d2_reg & vs_d1_reg;
    // A sync edge in the same cycle as a pixel takes priority; the pixel is dropped.
    assign pix_take  = gray_data_vld & armed_reg & ~vs_fall & ~vs_rise;
    assign in_roi    = (col_cnt_reg >= COL_LO) && (col_cnt_reg < COL_HI) &&
                       (row_cnt_reg >= ROW_LO) && (row_cnt_reg < ROW_HI);
    assign roi_pix   = pix_take & in_roi;
    assign blk_first = (sub_x_reg == '0) && (sub_y_reg == '0);
    assign blk_last  = (sub_x_reg == S_LAST) && (sub_y_reg == S_LAST);
    assign pix_ext   = {{(ACC_W - 8){1'b0}}, gray_data};
    assign sum_next  = acc[bx_reg] + pix_ext;

    // Per-column partial block sums; contents are never reset because the first
    // pixel of every block overwrites its entry.
    always_ff @(posedge sclk) begin
        if (roi_pix) begin
            acc[bx_reg] <= blk_first ? pix_ext : sum_next;
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            vs_d1_reg    <= 1'b0;
            vs_d2_reg    <= 1'b0;
            armed_reg    <= 1'b0;
            col_cnt_reg  <= '0;
            row_cnt_reg  <= '0;
            sub_x_reg    <= '0;
            sub_y_reg    <= '0;
            bx_reg       <= '0;
            out_cnt_reg  <= '0;
            vsync        <= 1'b0;
            bin_data_vld <= 1'b0;
            bin_data     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            vs_d1_reg    <= cmos_vsync;
            vs_d2_reg    <= vs_d1_reg;
            vsync        <= vs_fall;
            bin_data_vld <= 1'b0;
            frame_done   <= 1'b0;

            if (vs_fall || (vs_rise && armed_reg)) begin
                armed_reg   <= vs_fall;
                col_cnt_reg <= '0;
                row_cnt_reg <= '0;
                sub_x_reg   <= '0;
                sub_y_reg   <= '0;
                bx_reg      <= '0;
                out_cnt_reg <= '0;
            end else if (pix_take) begin
                if (col_cnt_reg == COL_LAST) begin
                    col_cnt_reg <= '0;
                    if (row_cnt_reg == ROW_LAST) begin
                        row_cnt_reg <= '0;
                        armed_reg   <= 1'b0;
                    end else begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                end else begin
                    col_cnt_reg <= col_cnt_reg + 1'b1;
                end

                if (in_roi) begin
                    if (sub_x_reg == S_LAST) begin
                        sub_x_reg <= '0;
                        if (bx_reg == B_LAST) begin
                            bx_reg    <= '0;
                            sub_y_reg <= (sub_y_reg == S_LAST) ? '0 : sub_y_reg + 1'b1;
                        end else begin
                            bx_reg <= bx_reg + 1'b1;
                        end
                    end else begin
                        sub_x_reg <= sub_x_reg + 1'b1;
                    end

                    if (blk_last) begin
                        bin_data_vld <= 1'b1;
                        bin_data     <= (sum_next < THR_SUM);
                        out_cnt_reg  <= out_cnt_reg + 1'b1;
                        frame_done   <= (out_cnt_reg == O_LAST);
                    end
                end
            end
        end
    end

endmodule
